// File: rtl/noise_sampler.sv
// noise_sampler: rate-controlled sampler for the LMS noise LFSR.
// Drives LFSR enable/reseed, scales captured words, buffers them in a FWFT FIFO.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   start, stop       run control pulses (start only in IDLE, stop only in RUN)
//   div, shift        sample period minus 1 and right-shift amount, latched on start
//   lfsr_in           parallel LFSR state
//   lfsr_en, lfsr_rst LFSR advance enable and reseed request (combinational)
//   sample(_valid)    FIFO head and not-empty flag; sample_ready pops the head
//   level             FIFO occupancy
//   overflow          sticky dropped-sample flag
//   busy              state is not IDLE
module noise_sampler #(
    parameter int DIV_W      = 16,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start,
    input  logic                          stop,
    input  logic [DIV_W-1:0]              div,
    input  logic [3:0]                    shift,
    input  logic [15:0]                   lfsr_in,
    output logic                          lfsr_en,
    output logic                          lfsr_rst,
    output logic [15:0]                   sample,
    output logic                          sample_valid,
    input  logic                          sample_ready,
    output logic [$clog2(FIFO_DEPTH):0]   level,
    output logic                          overflow,
    output logic                          busy
);

    localparam int AW = $clog2(FIFO_DEPTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SEED,
        S_RUN
    } state_t;

    state_t            state_q, state_d;
    logic [DIV_W-1:0]  cnt_q, cnt_d;
    logic [DIV_W-1:0]  div_q;
    logic [3:0]        shift_q;
    logic              ovf_q, ovf_d;
    logic              accept;
    logic              tick;

    logic [15:0]       mem_q [FIFO_DEPTH];
    logic [AW-1:0]     rd_q, wr_q;
    logic [AW:0]       lvl_q, lvl_d;
    logic              full;
    logic              pop;
    logic              wr_en;
    logic [15:0]       scaled;

    // Control FSM, tick generator and LFSR control decode.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        accept   = 1'b0;
        tick     = 1'b0;
        lfsr_rst = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_SEED;
                    accept  = 1'b1;
                end
            end
            S_SEED: begin
                state_d  = S_RUN;
                cnt_d    = div_q;
                lfsr_rst = ~rst;
            end
            S_RUN: begin
                if (cnt_q == '0) begin
                    tick  = 1'b1;
                    cnt_d = div_q;
                end else begin
                    cnt_d = cnt_q - DIV_W'(1);
                end
                if (stop) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
        // A tick coinciding with reset is dropped, so the LFSR must not move.
        lfsr_en = tick & ~rst;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            div_q   <= '0;
            shift_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (accept) begin
                div_q   <= div;
                shift_q <= shift;
            end
        end
    end

    assign busy   = (state_q != S_IDLE);
    assign scaled = 16'($signed(lfsr_in) >>> shift_q);

    // FIFO: when full, a push is still taken if the head pops this cycle.
    assign full         = (lvl_q == (AW+1)'(FIFO_DEPTH));
    assign sample_valid = (lvl_q != '0);
    assign pop          = sample_valid & sample_ready;
    assign wr_en        = tick & (~full | pop);
    assign sample       = sample_valid ? mem_q[rd_q] : 16'h0000;
    assign level        = lvl_q;
    assign overflow     = ovf_q;

    always_comb begin
        lvl_d = lvl_q;
        unique case ({wr_en, pop})
            2'b10:   lvl_d = lvl_q + (AW+1)'(1);
            2'b01:   lvl_d = lvl_q - (AW+1)'(1);
            default: lvl_d = lvl_q;
        endcase
        ovf_d = ovf_q;
        if (accept) begin
            ovf_d = 1'b0;
        end else if (tick && full && !pop) begin
            ovf_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_q  <= '0;
            wr_q  <= '0;
            lvl_q <= '0;
            ovf_q <= 1'b0;
        end else begin
            lvl_q <= lvl_d;
            ovf_q <= ovf_d;
            if (wr_en) begin
                wr_q <= wr_q + AW'(1);
            end
            if (pop) begin
                rd_q <= rd_q + AW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_q] <= scaled;
        end
    end

endmodule
